// File: rtl/tang_uart_tx_top.sv
// Tang board UART demo: sends "Hello\r\n" as 8N1 frames, with an idle-high gap
// between repetitions. SW1 is a synchronous active-low reset.
module tang_uart_tx_top #(
    parameter int unsigned CLKS_PER_BIT = 208,
    parameter int unsigned GAP_CLKS     = 2400000
) (
    input  logic SYS_CLK,
    input  logic SW1,
    output logic LED1,
    output logic LED2,
    output logic TX_OUT
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);

    localparam logic [1:0] ST_GAP   = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic              tx_q, tx_d;
    logic              led1_q, led1_d;
    logic              led2_q, led2_d;
    logic [7:0]        cur_byte;
    logic [2:0]        bit_nxt;

    function automatic logic [7:0] msg_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    msg_byte = 8'h48;
            3'd1:    msg_byte = 8'h65;
            3'd2:    msg_byte = 8'h6C;
            3'd3:    msg_byte = 8'h6C;
            3'd4:    msg_byte = 8'h6F;
            3'd5:    msg_byte = 8'h0D;
            default: msg_byte = 8'h0A;
        endcase
    endfunction

    assign cur_byte = msg_byte(byte_q);
    assign bit_nxt  = bit_q + 3'd1;

    // Outputs are computed one cycle ahead so TX_OUT/LEDs come straight from flops.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        led1_d  = led1_q;
        led2_d  = led2_q;
        case (state_q)
            ST_GAP: begin
                tx_d   = 1'b1;
                led2_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = ST_START;
                    gap_d   = '0;
                    baud_d  = '0;
                    byte_d  = '0;
                    tx_d    = 1'b0;
                    led2_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_q == 3'd6) begin
                        state_d = ST_GAP;
                        byte_d  = '0;
                        gap_d   = '0;
                        tx_d    = 1'b1;
                        led2_d  = 1'b1;
                        led1_d  = ~led1_q;
                    end else begin
                        state_d = ST_START;
                        byte_d  = byte_q + 3'd1;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (!SW1) begin
            state_q <= ST_GAP;
            baud_q  <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            led1_q  <= 1'b1;
            led2_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            led1_q  <= led1_d;
            led2_q  <= led2_d;
        end
    end

    assign TX_OUT = tx_q;
    assign LED1   = led1_q;
    assign LED2   = led2_q;

endmodule

// File: tb/tb_tang_uart_tx_top.sv
// Bench for tang_uart_tx_top: per-cycle comparison against a position-in-period
// waveform model, plus a UART line decoder with literal byte and gap expectations.
module tb_tang_uart_tx_top;

    localparam int unsigned C = 4;
    localparam int unsigned G = 8;
    localparam int unsigned P = 70 * C + G;

    logic clk = 1'b0;
    logic sw1 = 1'b0;
    logic led1, led2, tx;

    int checks = 0;
    int errors = 0;
    int unsigned k = 0;

    always #5 clk = ~clk;

    tang_uart_tx_top #(
        .CLKS_PER_BIT(C),
        .GAP_CLKS(G)
    ) dut (
        .SYS_CLK(clk),
        .SW1(sw1),
        .LED1(led1),
        .LED2(led2),
        .TX_OUT(tx)
    );

    function automatic logic [7:0] msg(input int unsigned i);
        logic [7:0] rom [7];
        rom = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
        return rom[i];
    endfunction

    // k = edges since the last reset edge; the line is periodic in k with period P.
    function automatic logic exp_tx(input int unsigned kk);
        int unsigned p, f, b, s;
        logic [7:0] m;
        p = kk % P;
        if (p < G) return 1'b1;
        f = p - G;
        b = f / (10 * C);
        s = (f % (10 * C)) / C;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        m = msg(b);
        return m[s - 1];
    endfunction

    function automatic logic exp_led2(input int unsigned kk);
        return ((kk % P) < G) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_led1(input int unsigned kk);
        return ((kk / P) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d t=%0t: got %b expected %b", name, k, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin : compare
        logic s;
        forever begin
            @(posedge clk);
            s = sw1;
            #1;
            if (!s) k = 0;
            else    k++;
            check("tx_model", tx, exp_tx(k));
            check("led1_model", led1, exp_led1(k));
            check("led2_model", led2, exp_led2(k));
        end
    end

    // Called at the negedge just after the start-bit edge; returns at the next frame's start-bit negedge.
    task automatic rx_byte(output logic [7:0] d);
        repeat (2) @(negedge clk);
        check("rx_start", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            d[i] = tx;
        end
        repeat (C) @(negedge clk);
        check("rx_stop", tx, 1'b1);
        repeat (C - 2) @(negedge clk);
    endtask

    task automatic measure_high(output int hi);
        hi = 0;
        while (tx === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
        end
    endtask

    initial begin : stim
        int hi;
        logic [7:0] d;
        sw1 = 1'b0;
        repeat (5) @(negedge clk);
        sw1 = 1'b1;
        measure_high(hi);
        check_int("first_gap_len", hi, G);
        check("led2_start", led2, 1'b0);
        for (int b = 0; b < 7; b++) begin
            rx_byte(d);
            check_int("rx_byte", int'(d), int'(msg(b)));
        end
        check("led1_after_msg1", led1, 1'b0);
        check("led2_after_msg1", led2, 1'b1);
        measure_high(hi);
        check_int("repeat_gap_len", hi, G);
        repeat (70 * C) @(negedge clk);
        check("led1_after_msg2", led1, 1'b1);

        // Reset pulse in the middle of byte 2's data bits.
        repeat (G + 20 * C + C + 5) @(negedge clk);
        sw1 = 1'b0;
        @(negedge clk);
        sw1 = 1'b1;
        check("rst_tx", tx, 1'b1);
        check("rst_led1", led1, 1'b1);
        check("rst_led2", led2, 1'b1);
        measure_high(hi);
        check_int("post_rst_gap_len", hi, G);
        rx_byte(d);
        check_int("post_rst_byte", int'(d), 8'h48);

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            sw1 = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            sw1 = 1'b1;
        end
        repeat (2 * P + 5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
